// File: rtl/mult_cdb_buffer_if.sv
// Handshake bundle between issue stage, multiplier, CDB arbiter and the multiply result buffer.
// The slave modport is the buffer itself; the master modport is its environment.
interface mult_cdb_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned XLEN  = 32
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic             issue_start;
  logic             issue_ok;
  logic             mult_done;
  logic [TAG_W-1:0] mult_rob_tag;
  logic [XLEN-1:0]  mult_result;
  logic             cdb_req;
  logic             cdb_grant;
  logic [TAG_W-1:0] cdb_rob_tag;
  logic [XLEN-1:0]  cdb_result;
  logic             flush;
  logic [CntW-1:0]  occupancy;

  modport master (
    output issue_start, mult_done, mult_rob_tag, mult_result, cdb_grant, flush,
    input  issue_ok, cdb_req, cdb_rob_tag, cdb_result, occupancy
  );

  modport slave (
    input  issue_start, mult_done, mult_rob_tag, mult_result, cdb_grant, flush,
    output issue_ok, cdb_req, cdb_rob_tag, cdb_result, occupancy
  );
endinterface

// File: rtl/mult_cdb_buffer.sv
// Credit-controlled result buffer between the multiplier and the common data bus.
// Define MULT_BUF_BYPASS_EN to forward a result straight to the CDB when the buffer is empty.
module mult_cdb_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned XLEN  = 32
) (
  input logic              clk,
  input logic              reset,
  mult_cdb_buffer_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SumW = CntW + 2;

  logic [TAG_W-1:0] tag_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_d [DEPTH];
  logic [XLEN-1:0]  res_mem_q [DEPTH];
  logic [XLEN-1:0]  res_mem_d [DEPTH];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  occ_q, occ_d, inflight_q, inflight_d, discard_q, discard_d;

  logic discarding, accept, buf_req, bypass, push, pop;
  logic [SumW-1:0] credit_sum;

  always_comb begin
    discarding = (discard_q != '0);
    accept     = bus.mult_done && !discarding;
    buf_req    = (occ_q != '0);
`ifdef MULT_BUF_BYPASS_EN
    bypass     = reset && accept && !buf_req && !bus.flush;
`else
    bypass     = 1'b0;
`endif
    // A granted bypass result has already been broadcast, so it never enters the buffer.
    push       = accept && !bus.flush && !(bypass && bus.cdb_grant);
    pop        = buf_req && bus.cdb_grant && !bus.flush;
    credit_sum = SumW'(discard_q) + SumW'(inflight_q) + SumW'(occ_q);
  end

  always_comb begin
    tag_mem_d  = tag_mem_q;
    res_mem_d  = res_mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    if (bus.flush) begin
      // Everything still inside the multiplier must be dropped when it emerges.
      discard_d  = discard_q + inflight_q - CntW'(bus.mult_done);
      inflight_d = '0;
      occ_d      = '0;
      head_d     = tail_q;
    end else begin
      if (push) begin
        tag_mem_d[tail_q] = bus.mult_rob_tag;
        res_mem_d[tail_q] = bus.mult_result;
        tail_d            = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      occ_d      = occ_q + CntW'(push) - CntW'(pop);
      inflight_d = inflight_q + CntW'(bus.issue_start) - CntW'(accept);
      discard_d  = discard_q - CntW'(bus.mult_done && discarding);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_mem_q[i] <= '0;
        res_mem_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      tag_mem_q  <= tag_mem_d;
      res_mem_q  <= res_mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  // Credit is computed from registered state only; reset gating holds it low while in reset.
  assign bus.issue_ok    = reset && (credit_sum < SumW'(DEPTH));
  assign bus.cdb_req     = buf_req || bypass;
  assign bus.cdb_rob_tag = bypass ? bus.mult_rob_tag : tag_mem_q[head_q];
  assign bus.cdb_result  = bypass ? bus.mult_result : res_mem_q[head_q];
  assign bus.occupancy   = occ_q;
endmodule

// File: tb/tb_mult_cdb_buffer.sv
// Scoreboard bench for mult_cdb_buffer: a queue model of accepted results plus credit counters.
module tb_mult_cdb_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned XLEN  = 32;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  res;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ent_t exp_q[$];
  int   inflight_m = 0;
  int   discard_m = 0;

  mult_cdb_buffer_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) bus ();

  mult_cdb_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit credit_m();
    return (discard_m + inflight_m + exp_q.size()) < int'(DEPTH);
  endfunction

  // Drives one cycle of inputs, then applies its architectural effect to the model after the edge.
  task automatic cyc(input bit iss, input bit done, input logic [TAG_W-1:0] tag,
                     input logic [XLEN-1:0] res, input bit gnt, input bit fl);
    bit acc, push;
    bus.issue_start  = iss;
    bus.mult_done    = done;
    bus.mult_rob_tag = tag;
    bus.mult_result  = res;
    bus.cdb_grant    = gnt;
    bus.flush        = fl;
    acc  = done && (discard_m == 0);
    push = acc && !fl;
`ifdef MULT_BUF_BYPASS_EN
    if (exp_q.size() == 0 && gnt) push = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (fl) begin
      discard_m  = discard_m + inflight_m - int'(done);
      inflight_m = 0;
      exp_q.delete();
    end else begin
      if (done && discard_m > 0) discard_m--;
      inflight_m = inflight_m + int'(iss) - int'(acc);
      if (push) exp_q.push_back('{tag: tag, res: res});
    end
  endtask

  task automatic do_reset();
    bus.issue_start = 1'b0;
    bus.mult_done   = 1'b0;
    bus.cdb_grant   = 1'b0;
    bus.flush       = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    inflight_m = 0;
    discard_m  = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: compares registered outputs mid-cycle and retires the head on a granted request.
  int occ_e;
  bit byp_e;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_cdb_req", 64'(bus.cdb_req), 64'd0);
        chk("rst_issue_ok", 64'(bus.issue_ok), 64'd0);
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst_cdb_tag", 64'(bus.cdb_rob_tag), 64'd0);
        chk("rst_cdb_result", 64'(bus.cdb_result), 64'd0);
      end else begin
        occ_e = exp_q.size();
        byp_e = 1'b0;
`ifdef MULT_BUF_BYPASS_EN
        byp_e = (occ_e == 0) && bus.mult_done && (discard_m == 0) && !bus.flush;
`endif
        chk("occupancy", 64'(bus.occupancy), 64'(occ_e));
        chk("issue_ok", 64'(bus.issue_ok), 64'(credit_m()));
        chk("cdb_req", 64'(bus.cdb_req), 64'((occ_e != 0) || byp_e));
        if (occ_e != 0) begin
          chk("cdb_tag", 64'(bus.cdb_rob_tag), 64'(exp_q[0].tag));
          chk("cdb_result", 64'(bus.cdb_result), 64'(exp_q[0].res));
          if (bus.cdb_req && bus.cdb_grant && !bus.flush) void'(exp_q.pop_front());
        end else if (byp_e) begin
          chk("byp_tag", 64'(bus.cdb_rob_tag), 64'(bus.mult_rob_tag));
          chk("byp_result", 64'(bus.cdb_result), 64'(bus.mult_result));
        end
      end
    end
  end

  initial begin
    bus.issue_start  = 1'b0;
    bus.mult_done    = 1'b0;
    bus.mult_rob_tag = '0;
    bus.mult_result  = '0;
    bus.cdb_grant    = 1'b0;
    bus.flush        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Single multiply, tag 5 result 0x2A, grant held high.
    cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 1, 5, 32'h2A, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Exhaust credits with no grants, then free one slot with a single grant.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 5'(10 + i), 32'(100 + i), 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 1, 0);

    // Three rounds of tags 1,2,3 back-to-back with grant every other cycle.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 5'(i + 1), 32'(r * 16 + i), i[0], 0);
      repeat (4) cyc(0, 0, 0, 0, 1, 0);
    end

    // Near-full buffer with a push and a pop in the same cycle.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 5'(20 + i), 32'(200 + i), 0, 0);
    cyc(0, 1, 5'd23, 32'd203, 1, 0);
    repeat (4) cyc(0, 0, 0, 0, 1, 0);

    // Two buffered, two in flight, flush: the two stragglers are dropped.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 5'd1, 32'h11, 0, 0);
    cyc(0, 1, 5'd2, 32'h22, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 1, 5'd3, 32'h33, 1, 0);
    cyc(1, 1, 5'd4, 32'h44, 1, 0);
    cyc(0, 1, 5'd9, 32'h99, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);

    // Randomized traffic with a reset dropped in the middle.
    for (int i = 0; i < 3000; i++) begin
      bit iss, done, gnt, fl;
      if (i == 1500) do_reset();
      iss  = credit_m() && ($urandom_range(0, 2) != 0);
      done = (inflight_m + discard_m > 0) && ($urandom_range(0, 2) != 0);
      gnt  = ($urandom_range(0, 1) != 0);
      fl   = ($urandom_range(0, 40) == 0);
      cyc(iss, done, TAG_W'($urandom), $urandom, gnt, fl);
    end
    repeat (8) cyc(0, 0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
